// File: rtl/d_mem_checker_if.sv
// Bus between the printable-byte checker, d_memory and its status consumers.
// The master side is the checker; the slave side is the memory/control side.
interface d_mem_checker_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] d_mem_addr;
    logic [7:0]        d_mem_data_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic [ADDR_W-1:0] bad_index;

    modport master (
        input  start,
        input  d_mem_data_out,
        output d_mem_addr,
        output busy,
        output done,
        output pass,
        output fail,
        output bad_index
    );

    modport slave (
        output start,
        output d_mem_data_out,
        input  d_mem_addr,
        input  busy,
        input  done,
        input  pass,
        input  fail,
        input  bad_index
    );
endinterface

// File: rtl/d_mem_checker.sv
// Sweeps d_memory after decryption and checks each byte is 'a'..'z' or space.
// Reports pass/fail and the index of the first offending byte.
module d_mem_checker #(
    parameter int MSG_LEN    = 32,
    parameter int ADDR_W     = 8,
    parameter int RD_LATENCY = 2
) (
    input logic             clk,
    input logic             reset,
    d_mem_checker_if.master bus
);
    localparam int WAIT_W = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(MSG_LEN - 1);
    localparam logic [WAIT_W-1:0] WAIT_END = WAIT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] idx;
    logic [WAIT_W-1:0] wcnt;
    logic [7:0]        rd_byte;
    logic              pass_q;
    logic              fail_q;
    logic [ADDR_W-1:0] bad_q;
    logic              done_q;
    logic              done_d;
    logic              busy_c;
    logic              byte_ok;
    logic              wait_last;
    logic              last_byte;

    assign byte_ok   = (rd_byte == 8'h20)
                     || (rd_byte >= 8'h61 && rd_byte <= 8'h7A);
    assign wait_last = (wcnt == WAIT_END);
    assign last_byte = (idx == LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = READ;
            READ:    if (wait_last) state_n = CHECK;
            CHECK:   state_n = (!byte_ok || last_byte) ? DONE : READ;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state == READ) || (state == CHECK);
        done_d = (state == DONE);
    end

    // The terminal-index test precedes the increment, so idx never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            wcnt    <= '0;
            rd_byte <= '0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            bad_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done_d;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx    <= '0;
                        wcnt   <= '0;
                        pass_q <= 1'b0;
                        fail_q <= 1'b0;
                        bad_q  <= '0;
                    end
                end
                READ: begin
                    if (wait_last) begin
                        rd_byte <= bus.d_mem_data_out;
                        wcnt    <= '0;
                    end else begin
                        wcnt <= wcnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (!byte_ok) begin
                        fail_q <= 1'b1;
                        bad_q  <= idx;
                    end else if (last_byte) begin
                        pass_q <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.d_mem_addr = idx;
    assign bus.busy       = busy_c;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.fail       = fail_q;
    assign bus.bad_index  = bad_q;
endmodule

// File: tb/tb_d_mem_checker.sv
// Bench for d_mem_checker: registered-read memory model, vector table,
// hand-written corner sequences and a randomized run against a message model.
module tb_d_mem_checker;
    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 8;
    localparam int RD_LAT  = 2;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [7:0] mem [256];
    string msg = "the quick brown fox jumps over t";

    always #10 clk = ~clk;

    d_mem_checker_if #(.ADDR_W(ADDR_W)) bus ();

    d_mem_checker #(
        .MSG_LEN(MSG_LEN),
        .ADDR_W(ADDR_W),
        .RD_LATENCY(RD_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // One registered stage: data for an address is sampleable two edges later
    always_ff @(posedge clk) bus.d_mem_data_out <= mem[bus.d_mem_addr];

    typedef struct {
        logic [7:0] val0;
        int         exp_bad;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit printable(input logic [7:0] b);
        return (b == " ") || (b >= "a" && b <= "z");
    endfunction

    task automatic load_msg();
        for (int j = 0; j < 256; j++) mem[j] = 8'hFF;
        for (int j = 0; j < MSG_LEN; j++) mem[j] = msg[j];
    endtask

    function automatic void model(output bit p, output bit f, output int bad,
                                  output int cyc);
        p = 1'b1; f = 1'b0; bad = 0;
        for (int j = 0; j < MSG_LEN; j++) begin
            if (!printable(mem[j])) begin
                p = 1'b0; f = 1'b1; bad = j;
                break;
            end
        end
        cyc = (f ? bad + 1 : MSG_LEN) * (RD_LAT + 1) + 1;
    endfunction

    task automatic sweep(input bit poke, output int cyc, output logic p,
                         output logic f, output logic [7:0] bi,
                         output int maxa);
        bit   inv_ok;
        logic prev_done;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("accept_busy", 32'(bus.busy), 1);
        check("accept_clear", 32'({bus.pass, bus.fail, bus.bad_index}), 0);
        cyc = -1; maxa = 0; inv_ok = 1'b1; prev_done = 1'b0;
        p = 1'b0; f = 1'b0; bi = '0;
        for (int k = 1; k <= 400; k++) begin
            if (poke) bus.start = (k == 10 || k == 40);
            @(posedge clk); #1;
            if (bus.pass && bus.fail) inv_ok = 1'b0;
            if (int'(bus.d_mem_addr) >= MSG_LEN) inv_ok = 1'b0;
            if (bus.done && (prev_done || bus.busy)) inv_ok = 1'b0;
            if (int'(bus.d_mem_addr) > maxa) maxa = int'(bus.d_mem_addr);
            prev_done = bus.done;
            if (bus.done) begin
                cyc = k; p = bus.pass; f = bus.fail; bi = bus.bad_index;
                break;
            end
        end
        bus.start = 1'b0;
        check("done_seen", 32'(cyc >= 0), 1);
        @(posedge clk); #1;
        if (bus.done) inv_ok = 1'b0;
        check("invariants", 32'(inv_ok), 1);
    endtask

    task automatic run_expect(input string name, input bit poke,
                              input bit ep, input bit ef, input int ebad,
                              input int ecyc, input int emax);
        int         cyc;
        int         maxa;
        logic       p;
        logic       f;
        logic [7:0] bi;
        sweep(poke, cyc, p, f, bi, maxa);
        check({name, "_pass"}, 32'(p), 32'(ep));
        check({name, "_fail"}, 32'(f), 32'(ef));
        check({name, "_bad"}, 32'(bi), 32'(ebad));
        check({name, "_cycles"}, 32'(cyc), 32'(ecyc));
        check({name, "_maxaddr"}, 32'(maxa), 32'(emax));
    endtask

    initial begin
        vec_t vecs [$];
        bit   mp;
        bit   mf;
        int   mbad;
        int   mcyc;
        int   d1;
        int   d2;

        vecs.push_back('{8'h20, 10});
        vecs.push_back('{8'h61, 10});
        vecs.push_back('{8'h7A, 10});
        vecs.push_back('{8'h1F, 0});
        vecs.push_back('{8'h21, 0});
        vecs.push_back('{8'h60, 0});
        vecs.push_back('{8'h7B, 0});
        vecs.push_back('{8'h00, 0});
        vecs.push_back('{8'hFF, 0});

        reset = 1'b1;
        bus.start = 1'b0;
        load_msg();
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", 32'(bus.d_mem_addr), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_pass", 32'(bus.pass), 0);
        check("rst_fail", 32'(bus.fail), 0);
        check("rst_bad", 32'(bus.bad_index), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        run_expect("full_pass", 1'b0, 1'b1, 1'b0, 0, 97, 31);

        mem[5] = 8'h41;
        run_expect("byte5_A", 1'b0, 1'b0, 1'b1, 5, 19, 5);

        load_msg();
        mem[31] = 8'hFF;
        run_expect("byte31_FF", 1'b0, 1'b0, 1'b1, 31, 97, 31);

        foreach (vecs[v]) begin
            load_msg();
            mem[0]  = vecs[v].val0;
            mem[10] = 8'h00;
            run_expect($sformatf("bound_%02h", vecs[v].val0), 1'b0, 1'b0,
                       1'b1, vecs[v].exp_bad, (vecs[v].exp_bad + 1) * 3 + 1,
                       vecs[v].exp_bad);
        end

        load_msg();
        run_expect("busy_pokes", 1'b1, 1'b1, 1'b0, 0, 97, 31);

        // Reset in the middle of a sweep
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_outs", 32'({bus.d_mem_addr, bus.busy, bus.done,
              bus.pass, bus.fail, bus.bad_index}), 0);
        repeat (4) @(posedge clk);
        #1;
        check("midrst_idle", 32'({bus.d_mem_addr, bus.busy, bus.done}), 0);
        run_expect("after_rst", 1'b0, 1'b1, 1'b0, 0, 97, 31);

        // start tied high: back-to-back checks
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #1;
        d1 = -1; d2 = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                if (d1 < 0) d1 = k;
                else d2 = k;
            end
            if (k == 98) begin
                check("hold_clear", 32'({bus.pass, bus.fail}), 0);
                check("hold_busy", 32'(bus.busy), 1);
            end
            if (d2 >= 0) break;
        end
        check("hold_pass2", 32'(bus.pass), 1);
        bus.start = 1'b0;
        check("hold_first", 32'(d1), 97);
        check("hold_period", 32'(d2 - d1), 98);
        repeat (3) @(posedge clk);

        for (int r = 0; r < 25; r++) begin
            for (int j = 0; j < MSG_LEN; j++) begin
                if ($urandom_range(0, 26) == 26) mem[j] = " ";
                else mem[j] = 8'h61 + 8'($urandom_range(0, 25));
            end
            if ($urandom_range(0, 3) != 0)
                mem[$urandom_range(0, MSG_LEN - 1)] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0)
                mem[$urandom_range(0, MSG_LEN - 1)] = 8'($urandom_range(0, 255));
            model(mp, mf, mbad, mcyc);
            run_expect($sformatf("rand%0d", r), 1'b0, mp, mf, mbad, mcyc,
                       mf ? mbad : MSG_LEN - 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/d_mem_checker.md
Name: d_mem_checker

Overview:
- Reader-side counterpart to the decryption datapath that writes decrypted message bytes into d_memory.
- After decryption finishes, sweeps d_memory from address 0 to MSG_LEN-1 and checks that every byte is printable: lowercase 'a'–'z' or space.
- Reports pass or fail, plus the index of the first offending byte.
- Consumed by the key-search control and the LED/HEX status logic.

Parameters:
- MSG_LEN, 32, number of message bytes to check (addresses 0..MSG_LEN-1); legal range 1..256.
- ADDR_W, 8, width of the d_memory address.
- RD_LATENCY, 2, clock edges from the first cycle an address is driven to the edge at which d_mem_data_out is sampled; minimum 1.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- start  in  1  level; begins a check when sampled high in IDLE
- d_mem_addr  out  ADDR_W  read address into d_memory
- d_mem_data_out  in  8  d_memory read data (q)
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse when the result is final
- pass  out  1  all bytes valid; held until the next start is accepted
- fail  out  1  an invalid byte was found; held until the next start is accepted
- bad_index  out  ADDR_W  index of the first invalid byte; valid while fail=1, else 0

Behaviour:
- Reset (synchronous, active-high, overrides all activity including mid-sweep):
  - state=IDLE
  - d_mem_addr=0, busy=0, done=0, pass=0, fail=0, bad_index=0.
- The block never writes d_memory; the memory's write enable is owned elsewhere.
- Valid byte: 8'h20, or 8'h61..8'h7A inclusive. All other values are invalid, including 8'h00, 8'h1F, 8'h21, 8'h60, 8'h7B and 8'hFF.
- FSM states: IDLE, READ, CHECK, DONE.
- IDLE:
  - start=1 at edge E0: go to READ, addr counter i=0, busy=1.
  - pass, fail and bad_index clear at E0.
  - start is ignored in every other state.
- READ:
  - d_mem_addr=i, held stable throughout.
  - The state lasts RD_LATENCY cycles (wait counter).
  - On the final READ edge, d_mem_data_out is registered into a byte register; go to CHECK.
- CHECK (1 cycle), evaluates the registered byte:
  - Invalid: fail=1, bad_index=i; go to DONE.
  - Valid and i==MSG_LEN-1: pass=1; go to DONE.
  - Valid otherwise: i=i+1; go to READ.
  - i never wraps; the terminal test precedes the increment.
- DONE (1 cycle): done=1, busy=0; then IDLE.
  - If start is still high, a new check is accepted on the following edge, so start may be tied high to recheck continuously.
- Timing:
  - Each byte costs RD_LATENCY+1 cycles.
  - Full pass: done is high in the cycle after edge E0 + MSG_LEN*(RD_LATENCY+1) + 1. Defaults: 32*3 = 96 cycles of sweep.
  - Fail at index j: done after E0 + (j+1)*(RD_LATENCY+1) + 1.
  - No address beyond j is presented after a fail.
- Invariants:
  - pass and fail are never both 1.
  - done is never high for 2 consecutive cycles.
  - busy=0 whenever state is IDLE or DONE.
  - d_mem_addr < MSG_LEN always.
- Widths: i and bad_index are ADDR_W bits; the wait counter is wide enough to hold RD_LATENCY.

Test Plan:
- Memory model with RD_LATENCY=2; d_memory holds "the quick brown fox jumps over t" (32 valid bytes); start pulsed -> d_mem_addr steps 0..31, each address held 2 cycles; done pulses once 97 cycles after E0; pass=1, fail=0, bad_index=0.
- Same message with byte 5 = 8'h41 ('A') -> fail=1, bad_index=5, done 19 cycles after E0; max d_mem_addr observed = 5.
- Boundary sweep, placing each value at index 0 in separate runs:
  - 8'h20, 8'h61, 8'h7A -> first byte accepted (fail stays 0 until a later invalid byte is reached).
  - 8'h1F, 8'h21, 8'h60, 8'h7B -> fail=1, bad_index=0.
- Only byte 31 = 8'hFF -> fail=1, bad_index=31; counter does not wrap to 0.
- reset asserted for 1 cycle at cycle 40 of a sweep -> next cycle all outputs 0 and state IDLE; subsequent start gives a full correct pass.
- start held high continuously -> back-to-back checks, one done per 98-cycle period; start pulses during busy are ignored; pass/fail clear on each acceptance.
